// File: rtl/control_unit.sv
// control_unit -- hardwired multi-cycle control FSM for the 5-bit-opcode CPU.
//
// Sequences fetch (T0-T2), decode and execute (T3-T7) and the halt/stop run
// control, driving every control input of the datapath. Outputs are decoded
// from the current phase and IR[31:27]; IR is stable from T3 on, so there is
// no separate opcode latch.
//
// Ports:
//   clock, clear          clock; asynchronous active-high reset to RESET
//   IR[31:0]              instruction register (opcode = IR[31:27])
//   CON                   branch condition, consulted in br T6
//   Stop                  halt request, sampled at the T2->T3 boundary
//   Run                   1 while in T0..T7
//   *out                  bus source selects (Yout is tied low)
//   Gra/Grb/Grc/Rin/Rout/BAout  register-field select and encode controls
//   *in, IncPC, Read, Write     register load enables and memory strobes
//   opcode[OP_W-1:0]      ALU operation
//   Illegal               only with CU_ILLEGAL_HALT_EN: sticky flag set when
//                         a reserved opcode (11100-11111) halts the machine
//
// Build option: define CU_ILLEGAL_HALT_EN to trap reserved opcodes into
// HALT; otherwise they execute as nop.
module control_unit #(
  parameter int              OP_W   = 5,
  parameter logic [OP_W-1:0] ADD_OP = 5'b00011
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     IR,
  input  logic            CON,
  input  logic            Stop,
  output logic            Run,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            InPortout,
  output logic            Cout,
  output logic            Yout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            CONin,
  output logic            HIin,
  output logic            LOin,
  output logic            ZHighIn,
  output logic            ZLowIn,
  output logic            OutPortin,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
`ifdef CU_ILLEGAL_HALT_EN
  output logic            Illegal,
`endif
  output logic [OP_W-1:0] opcode
);

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10101;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;
  localparam logic [OP_W-1:0] OP_RSV  = 5'b11100;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t r_state, w_next, w_last;

  logic [OP_W-1:0] w_op;
  logic w_alu, w_imm, w_md, w_un, w_ld, w_ldi, w_st, w_br, w_jr, w_jal;
  logic w_in, w_out, w_mflo, w_mfhi, w_halt, w_trap;
  logic w_unused_ir;

  assign w_op   = IR[31 -: OP_W];
  assign w_alu  = w_op inside {[OP_ADD:OP_SHL]};
  assign w_imm  = w_op inside {[OP_ADDI:OP_ORI]};
  assign w_md   = (w_op == OP_DIV) || (w_op == OP_MUL);
  assign w_un   = (w_op == OP_NEG) || (w_op == OP_NOT);
  assign w_ld   = (w_op == OP_LD);
  assign w_ldi  = (w_op == OP_LDI);
  assign w_st   = (w_op == OP_ST);
  assign w_br   = (w_op == OP_BR);
  assign w_jr   = (w_op == OP_JR);
  assign w_jal  = (w_op == OP_JAL);
  assign w_in   = (w_op == OP_IN);
  assign w_out  = (w_op == OP_OUT);
  assign w_mflo = (w_op == OP_MFLO);
  assign w_mfhi = (w_op == OP_MFHI);
  assign w_halt = (w_op == OP_HALT);

  // Operand fields are decoded by the datapath, not here.
  assign w_unused_ir = ^IR[31-OP_W:0];

`ifdef CU_ILLEGAL_HALT_EN
  logic w_rsv;
  logic r_illegal;
  assign w_rsv   = (w_op >= OP_RSV);
  assign w_trap  = w_halt || w_rsv;
  assign Illegal = r_illegal;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)                        r_illegal <= 1'b0;
    else if (r_state == S_T3 && w_rsv) r_illegal <= 1'b1;
  end
`else
  assign w_trap = w_halt;
`endif

  // Final execute phase of each instruction; reserved opcodes fall through
  // to T3 and so behave as nop unless trapped above.
  always_comb begin
    w_last = S_T3;
    if (w_ld || w_st)                w_last = S_T7;
    else if (w_md || w_br)           w_last = S_T6;
    else if (w_alu || w_imm || w_ldi) w_last = S_T5;
    else if (w_un || w_jal)          w_last = S_T4;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_RESET;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2:    w_next = Stop ? S_HALT : S_T3;
      S_HALT:  w_next = S_HALT;
      default: begin
        if (r_state == S_T3 && w_trap) w_next = S_HALT;
        else if (r_state == w_last)    w_next = S_T0;
        else begin
          case (r_state)
            S_T3:    w_next = S_T4;
            S_T4:    w_next = S_T5;
            S_T5:    w_next = S_T6;
            S_T6:    w_next = S_T7;
            default: w_next = S_T0;
          endcase
        end
      end
    endcase
  end

  assign Yout = 1'b0;

  always_comb begin
    Run = 1'b0;
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    CONin = 1'b0; HIin = 1'b0; LOin = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0;
    OutPortin = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    opcode = '0;
    case (r_state)
      S_T0: begin Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
      S_T1: begin Run = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        Run = 1'b1;
        if (w_alu || w_imm)                 begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (w_md)                      begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (w_un)                      begin Grb = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; opcode = w_op; end
        else if (w_ld || w_ldi || w_st)     begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else if (w_br)                      begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        else if (w_jr)                      begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        else if (w_jal)                     begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
        else if (w_in)                      begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (w_out)                     begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
        else if (w_mflo)                    begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (w_mfhi)                    begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      S_T4: begin
        Run = 1'b1;
        if (w_alu)                          begin Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; opcode = w_op; end
        else if (w_imm)                     begin Cout = 1'b1; ZLowIn = 1'b1; opcode = w_op; end
        else if (w_md)                      begin Grb = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; opcode = w_op; end
        else if (w_un)                      begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (w_ld || w_ldi || w_st)     begin Cout = 1'b1; ZLowIn = 1'b1; opcode = ADD_OP; end
        else if (w_br)                      begin PCout = 1'b1; Yin = 1'b1; end
        else if (w_jal)                     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
      end
      S_T5: begin
        Run = 1'b1;
        if (w_alu || w_imm || w_ldi)        begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (w_md)                      begin Zlowout = 1'b1; LOin = 1'b1; end
        else if (w_ld || w_st)              begin Zlowout = 1'b1; MARin = 1'b1; end
        else if (w_br)                      begin Cout = 1'b1; ZLowIn = 1'b1; opcode = ADD_OP; end
      end
      S_T6: begin
        Run = 1'b1;
        if (w_md)                           begin Zhighout = 1'b1; HIin = 1'b1; end
        else if (w_ld)                      begin Read = 1'b1; MDRin = 1'b1; end
        else if (w_st)                      begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        // Branch target is always on the bus; only a taken branch loads PC.
        else if (w_br)                      begin Zlowout = 1'b1; PCin = CON; end
      end
      S_T7: begin
        Run = 1'b1;
        if (w_ld)                           begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (w_st)                      Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clock, clear, CON, Stop;
  logic [31:0] IR;
  logic Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, Yout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, MARin, PCin, MDRin, IRin, Yin, CONin;
  logic HIin, LOin, ZHighIn, ZLowIn, OutPortin, IncPC, Read, Write;
  logic [4:0] opcode;
`ifdef CU_ILLEGAL_HALT_EN
  logic Illegal;
`endif

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .Yout(Yout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .CONin(CONin), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write),
`ifdef CU_ILLEGAL_HALT_EN
    .Illegal(Illegal),
`endif
    .opcode(opcode)
  );

  always #5 clock = ~clock;

  // Whole control word, one bit per strobe, opcode on top.
  logic [34:0] act;
  assign act = {opcode, Run, Write, Read, IncPC, OutPortin, ZLowIn, ZHighIn,
                LOin, HIin, CONin, Yin, IRin, MDRin, PCin, MARin, BAout, Rout,
                Rin, Grc, Grb, Gra, Yout, Cout, InPortout, LOout, HIout, MDRout,
                Zlowout, Zhighout, PCout};

  localparam logic [34:0] M_PCOUT = 35'd1 << 0,  M_ZHIGHOUT = 35'd1 << 1;
  localparam logic [34:0] M_ZLOWOUT = 35'd1 << 2, M_MDROUT = 35'd1 << 3;
  localparam logic [34:0] M_HIOUT = 35'd1 << 4,  M_LOOUT = 35'd1 << 5;
  localparam logic [34:0] M_INPORTOUT = 35'd1 << 6, M_COUT = 35'd1 << 7;
  localparam logic [34:0] M_GRA = 35'd1 << 9,    M_GRB = 35'd1 << 10;
  localparam logic [34:0] M_GRC = 35'd1 << 11,   M_RIN = 35'd1 << 12;
  localparam logic [34:0] M_ROUT = 35'd1 << 13,  M_BAOUT = 35'd1 << 14;
  localparam logic [34:0] M_MARIN = 35'd1 << 15, M_PCIN = 35'd1 << 16;
  localparam logic [34:0] M_MDRIN = 35'd1 << 17, M_IRIN = 35'd1 << 18;
  localparam logic [34:0] M_YIN = 35'd1 << 19,   M_CONIN = 35'd1 << 20;
  localparam logic [34:0] M_HIIN = 35'd1 << 21,  M_LOIN = 35'd1 << 22;
  localparam logic [34:0] M_ZHIGHIN = 35'd1 << 23, M_ZLOWIN = 35'd1 << 24;
  localparam logic [34:0] M_OUTPORTIN = 35'd1 << 25, M_INCPC = 35'd1 << 26;
  localparam logic [34:0] M_READ = 35'd1 << 27,  M_WRITE = 35'd1 << 28;
  localparam logic [34:0] M_RUN = 35'd1 << 29;
  localparam logic [34:0] FETCH_W = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_PCIN;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the list of control words one instruction should produce,
  // T0 first, straight from the per-instruction step table.
  logic [34:0] mq[$];
  bit          m_halt;

  function automatic logic [34:0] opc(input logic [4:0] op);
    return {op, 30'd0};
  endfunction

  function automatic void step(input logic [34:0] w);
    mq.push_back(w | M_RUN);
  endfunction

  function automatic void model(input logic [4:0] op, input logic con, input logic stp);
    mq.delete();
    m_halt = 1'b0;
    step(M_PCOUT | M_MARIN | M_INCPC | M_PCIN);
    step(M_READ | M_MDRIN);
    step(M_MDROUT | M_IRIN);
    if (stp) begin m_halt = 1'b1; return; end
    if (op >= 5'd3 && op <= 5'd11) begin
      step(M_GRB | M_ROUT | M_YIN);
      step(M_GRC | M_ROUT | M_ZLOWIN | opc(op));
      step(M_ZLOWOUT | M_GRA | M_RIN);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      step(M_GRB | M_ROUT | M_YIN);
      step(M_COUT | M_ZLOWIN | opc(op));
      step(M_ZLOWOUT | M_GRA | M_RIN);
    end else if (op == 5'd15 || op == 5'd16) begin
      step(M_GRA | M_ROUT | M_YIN);
      step(M_GRB | M_ROUT | M_ZHIGHIN | M_ZLOWIN | opc(op));
      step(M_ZLOWOUT | M_LOIN);
      step(M_ZHIGHOUT | M_HIIN);
    end else if (op == 5'd17 || op == 5'd18) begin
      step(M_GRB | M_ROUT | M_ZLOWIN | opc(op));
      step(M_ZLOWOUT | M_GRA | M_RIN);
    end else if (op <= 5'd2) begin
      step(M_GRB | M_BAOUT | M_YIN);
      step(M_COUT | M_ZLOWIN | opc(5'b00011));
      if (op == 5'd1) step(M_ZLOWOUT | M_GRA | M_RIN);
      else begin
        step(M_ZLOWOUT | M_MARIN);
        if (op == 5'd0) begin
          step(M_READ | M_MDRIN);
          step(M_MDROUT | M_GRA | M_RIN);
        end else begin
          step(M_GRA | M_ROUT | M_MDRIN);
          step(M_WRITE);
        end
      end
    end else if (op == 5'd19) begin
      step(M_GRA | M_ROUT | M_CONIN);
      step(M_PCOUT | M_YIN);
      step(M_COUT | M_ZLOWIN | opc(5'b00011));
      step(M_ZLOWOUT | (con ? M_PCIN : 35'd0));
    end else if (op == 5'd20) begin
      step(M_PCOUT | M_GRB | M_RIN);
      step(M_GRA | M_ROUT | M_PCIN);
    end else if (op == 5'd21) step(M_GRA | M_ROUT | M_PCIN);
    else if (op == 5'd22) step(M_INPORTOUT | M_GRA | M_RIN);
    else if (op == 5'd23) step(M_GRA | M_ROUT | M_OUTPORTIN);
    else if (op == 5'd24) step(M_LOOUT | M_GRA | M_RIN);
    else if (op == 5'd25) step(M_HIOUT | M_GRA | M_RIN);
    else if (op == 5'd26) step('0);
    else if (op == 5'd27) begin step('0); m_halt = 1'b1; end
    else begin
      step('0);
`ifdef CU_ILLEGAL_HALT_EN
      m_halt = 1'b1;
`endif
    end
  endfunction

  task automatic chk(input string nm, input logic [34:0] a, input logic [34:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk_i(input string nm, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // Called just after a negedge; leaves the bench at the negedge of T0.
  task automatic do_reset();
    Stop  = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    chk("reset_state", act, '0);
    clear = 1'b0;
    @(negedge clock);
    chk("reset_fetch", act, FETCH_W);
  endtask

  // Entered at the negedge of T0. Walks the DUT until it shows a new fetch
  // or drops Run, checking each step against the model; returns the
  // measured length in cycles (T0 included) and whether it halted.
  task automatic run_instr(input logic [31:0] ir, input logic con, input logic stp,
                           output int len, output bit halted);
    int k;
    model(ir[31:27], con, stp);
    IR  = ir;
    CON = con;
    for (k = 1; k < 16; k++) begin
      @(negedge clock);
      if (act === FETCH_W || act[29] !== 1'b1) break;
      chk($sformatf("op%02h_T%0d", ir[31:27], k), act,
          (k < mq.size()) ? mq[k] : FETCH_W);
      if (k == 1 && stp) Stop = 1'b1;
    end
    len    = k;
    halted = (act[29] !== 1'b1);
    if (halted) begin
      repeat (20) begin
        @(negedge clock);
        chk($sformatf("op%02h_halt_hold", ir[31:27]), act, '0);
      end
      do_reset();
    end else if (k == 16) begin
      do_reset();
    end
  endtask

  typedef struct {
    logic [31:0] ir;
    logic        con;
    logic        stp;
    int          len;
    bit          halt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  len;
    bit  h;
    logic [4:0] op;
    logic c, s;

    clock = 1'b0; clear = 1'b1; IR = '0; CON = 1'b0; Stop = 1'b0;

    tbl.push_back('{32'h1880_0000, 1'b0, 1'b0, 6, 1'b0}); // add
    tbl.push_back('{32'h0000_0000, 1'b0, 1'b0, 8, 1'b0}); // ld
    tbl.push_back('{32'h0800_0000, 1'b0, 1'b0, 6, 1'b0}); // ldi
    tbl.push_back('{32'h1000_0000, 1'b0, 1'b0, 8, 1'b0}); // st
    tbl.push_back('{32'h6000_0000, 1'b1, 1'b0, 6, 1'b0}); // addi
    tbl.push_back('{32'h7800_0000, 1'b0, 1'b0, 7, 1'b0}); // div
    tbl.push_back('{32'h8000_0000, 1'b0, 1'b0, 7, 1'b0}); // mul
    tbl.push_back('{32'h8800_0000, 1'b0, 1'b0, 5, 1'b0}); // neg
    tbl.push_back('{32'h9800_0000, 1'b0, 1'b0, 7, 1'b0}); // br not taken
    tbl.push_back('{32'h9800_0000, 1'b1, 1'b0, 7, 1'b0}); // br taken
    tbl.push_back('{32'hA000_0000, 1'b0, 1'b0, 5, 1'b0}); // jal
    tbl.push_back('{32'hA800_0000, 1'b0, 1'b0, 4, 1'b0}); // jr
    tbl.push_back('{32'hB000_0000, 1'b0, 1'b0, 4, 1'b0}); // in
    tbl.push_back('{32'hB800_0000, 1'b0, 1'b0, 4, 1'b0}); // out
    tbl.push_back('{32'hC000_0000, 1'b0, 1'b0, 4, 1'b0}); // mflo
    tbl.push_back('{32'hC800_0000, 1'b0, 1'b0, 4, 1'b0}); // mfhi
    tbl.push_back('{32'hD000_0000, 1'b0, 1'b0, 4, 1'b0}); // nop
    tbl.push_back('{32'hD800_0000, 1'b0, 1'b0, 4, 1'b1}); // halt
    tbl.push_back('{32'hD000_0000, 1'b0, 1'b1, 3, 1'b1}); // Stop during nop fetch
`ifdef CU_ILLEGAL_HALT_EN
    tbl.push_back('{32'hE000_0000, 1'b0, 1'b0, 4, 1'b1}); // reserved opcode traps
`else
    tbl.push_back('{32'hE000_0000, 1'b0, 1'b0, 4, 1'b0}); // reserved opcode = nop
`endif

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      run_instr(tbl[i].ir, tbl[i].con, tbl[i].stp, len, h);
      chk_i($sformatf("vec%0d_len", i), len, tbl[i].len);
      chk_i($sformatf("vec%0d_halt", i), int'(h), int'(tbl[i].halt));
    end

    // clear asserted mid-T5 of mul: outputs drop at once, fetch resumes.
    IR = 32'h8000_0000;
    CON = 1'b0;
    model(5'b10000, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk($sformatf("mulclr_T%0d", k), act, mq[k]);
    end
    #1 clear = 1'b1;
    #1 chk("mulclr_async_zero", act, '0);
    @(negedge clock);
    chk("mulclr_held", act, '0);
    clear = 1'b0;
    @(negedge clock);
    chk("mulclr_fetch", act, FETCH_W);

    // Randomized instruction stream against the step-table model.
    for (int i = 0; i < 80; i++) begin
      op = 5'($urandom_range(0, 31));
      c  = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 7) == 0);
      run_instr({op, 27'($urandom)}, c, s, len, h);
      chk_i($sformatf("rnd%0d_op%02h_len", i, op), len, mq.size());
      chk_i($sformatf("rnd%0d_op%02h_halt", i, op), int'(h), int'(m_halt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
